reg_file_rd_streamer: RTL and testbench
=======================================

# reg_file_rd_streamer

Read sequencer that sits directly downstream of the two-read-port register file: on a start command it walks a contiguous address range through one read port (1-cycle read latency), absorbs the latency in a 2-entry output buffer, and presents the words as a valid/ready stream with a last flag. It sustains one word per cycle under no backpressure and never loses or duplicates a word when the consumer stalls.

## Interface
- DATA_WIDTH, 32, width of a register-file word
- ADDR_WIDTH, 4, register-file address width (2^ADDR_WIDTH entries)

- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  command strobe; accepted only when busy=0
- base_addr  in  ADDR_WIDTH  first address, sampled with start
- num_words  in  ADDR_WIDTH+1  word count 0..2^ADDR_WIDTH, sampled with start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when a command completes
- rf_rd_req  out  1  register-file read enable
- rf_rd_addr  out  ADDR_WIDTH  register-file read address
- rf_rd_data  in  DATA_WIDTH  register-file read data, valid the cycle after rf_rd_req
- out_valid  out  1  stream word available
- out_ready  in  1  consumer accepts word when out_valid & out_ready
- out_data  out  DATA_WIDTH  stream word
- out_last  out  1  high with the final word of a command

## Operation
- Reset values: busy=0, done=0, rf_rd_req=0, rf_rd_addr=0, out_valid=0, out_data=0, out_last=0; FSM in IDLE, all counters 0, buffer empty, inflight=0.
- FSM states: IDLE, READ, DRAIN.
  - IDLE: start=1 with num_words≠0 → latch base_addr and num_words into addr/remaining counters, go READ. start=1 with num_words=0 → go DRAIN with nothing outstanding (done pulses next cycle, no reads). start=0 → stay.
  - READ: issue reads; when the final read is issued (remaining reaches 0) go DRAIN.
  - DRAIN: wait until inflight=0 and buffer empty; then pulse done for one cycle and return to IDLE.
- start while busy=1 is ignored; no queuing.
- Read issue: rf_rd_req=1 in a cycle iff state=READ, remaining>0 and (fifo_count + inflight − pop) < 2, where pop = out_valid & out_ready. On issue: rf_rd_addr=current addr, addr ← addr+1 modulo 2^ADDR_WIDTH (wrap 2^ADDR_WIDTH−1 → 0), remaining ← remaining−1.
- inflight register = rf_rd_req of the previous cycle; when set, rf_rd_data is written into the buffer at the end of that cycle. rf_rd_data is ignored when inflight=0.
- Buffer: 2-entry FIFO, head drives out_data/out_valid. Simultaneous write and pop in one cycle allowed. The issue rule guarantees it never overflows; overflow is an assertion failure.
- out_last stored per entry: set on the entry produced by the final read of the command.
- rf_rd_addr holds its last value when rf_rd_req=0.

## Timing
- Start accepted at cycle 0 → busy=1 and first rf_rd_req in cycle 1 → rf_rd_data valid cycle 2 → out_valid=1 cycle 3.
- With out_ready held high: one read per cycle, one output per cycle; N words occupy out_valid cycles 3..N+2; done pulses in cycle N+3 with busy=0 from cycle N+4; a new start is accepted in cycle N+4.
- num_words=0: start at cycle 0 → busy=1 cycle 1, done=1 cycle 2, no rf_rd_req.
- Backpressure: out_valid/out_data/out_last held stable while out_valid=1 and out_ready=0; reads stall once fifo_count+inflight reaches 2 and resume the cycle out_ready returns.
- Reset asserted mid-command: all state and outputs return to reset values immediately; outstanding data discarded; no done pulse.

## Test plan
- base_addr=3, num_words=4, out_ready=1, mem[k]=0xA0+k → rf_rd_addr 3,4,5,6 in cycles 1–4; out_data 0xA3..0xA6 in cycles 3–6, out_last only with 0xA6; done in cycle 7.
- Same command, out_ready toggled 1,0,0,1,0,1,... → exactly 4 transfers, values in order 0xA3..0xA6, no duplicates; fifo_count+inflight ≤ 2 throughout; out_data stable while stalled.
- base_addr=14, num_words=4, ADDR_WIDTH=4 → reads addresses 14,15,0,1; output order matches.
- num_words=16, base_addr=0 → 16 words, addresses 0..15, out_last on word 16 only; num_words=0 → done at cycle 2, zero reads, zero outputs.
- start pulsed again during a 4-word command with different base → ignored; original 4 words only.
- resetn pulled low after 2 of 6 words transferred with out_ready=0 → all outputs 0 asynchronously, no done; after release, a fresh start (base 0, 2 words) streams correctly.

Source files
------------

// File: rtl/reg_file_rd_streamer.sv
// reg_file_rd_streamer: walks an address range through a 1-cycle-latency register-file read port
// and emits the words as a valid/ready stream with a last flag, buffered in a 2-entry FIFO.
`default_nettype none

module reg_file_rd_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  rf_rd_req,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0] last_addr_q;
  logic                  done_q, done_d;
  logic                  inflight_q;
  logic                  inflight_last_q;

  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic                  fifo_last_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q, count_d;

  logic                  pop;
  logic                  final_issue;
  logic [2:0]            occupancy;

  assign out_valid  = (count_q != 2'd0);
  assign pop        = out_valid & out_ready;
  assign out_data   = fifo_data_q[rd_ptr_q];
  assign out_last   = out_valid & fifo_last_q[rd_ptr_q];
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;

  // Slots already committed after this cycle's pop; a new read needs one free slot.
  assign occupancy  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rf_rd_req  = (state_q == S_READ) && (remaining_q != '0) && (occupancy < 3'd2);
  assign rf_rd_addr = rf_rd_req ? addr_q : last_addr_q;
  assign final_issue = rf_rd_req && (remaining_q == {{ADDR_WIDTH{1'b0}}, 1'b1});
  assign count_d    = count_q + {1'b0, inflight_q} - {1'b0, pop};

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_words != '0) begin
            addr_d      = base_addr;
            remaining_d = num_words;
            state_d     = S_READ;
          end else begin
            state_d     = S_DRAIN;
          end
        end
      end
      S_READ: begin
        if (rf_rd_req) begin
          addr_d      = addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (final_issue) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // No reads are issued here, so the buffer emptying this cycle means nothing is left.
        if (done_q) state_d = S_IDLE;
        else        done_d  = (count_d == 2'd0);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      last_addr_q     <= '0;
      done_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
      fifo_data_q[0]  <= '0;
      fifo_data_q[1]  <= '0;
      fifo_last_q[0]  <= 1'b0;
      fifo_last_q[1]  <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      done_q          <= done_d;
      inflight_q      <= rf_rd_req;
      inflight_last_q <= final_issue;
      count_q         <= count_d;
      if (rf_rd_req) last_addr_q <= addr_q;
      if (inflight_q) begin
        fifo_data_q[wr_ptr_q] <= rf_rd_data;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !(inflight_q && (count_q == 2'd2) && !pop));

endmodule

`default_nettype wire

// File: tb/tb_reg_file_rd_streamer.sv
// Directed self-checking bench for reg_file_rd_streamer with a 1-cycle-latency memory model.
`default_nettype none

module tb_reg_file_rd_streamer;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_words;
  logic          busy, done, rf_rd_req;
  logic [AW-1:0] rf_rd_addr;
  logic [DW-1:0] rf_rd_data;
  logic          out_valid, out_ready, out_last;
  logic [DW-1:0] out_data;

  always #5 clk = ~clk;

  reg_file_rd_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done), .rf_rd_req(rf_rd_req),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memv(input logic [AW-1:0] a);
    return 32'hA0 + {28'd0, a};
  endfunction

  function automatic logic ready_for(input int mode, input int cyc);
    logic [5:0] pat;
    pat = 6'b101001;  // cycle 0 -> bit0: 1,0,0,1,0,1
    case (mode)
      1:       return pat[cyc % 6];
      2:       return (cyc < 5);
      default: return 1'b1;
    endcase
  endfunction

  // Per-command observations
  int nreads, nout, nlast, ndone, done_cyc, first_rd_cyc, first_out_cyc, last_out_cyc;
  int occ_viol, stall_viol, occ;
  logic busy_c1, busy_after_done;
  logic [AW-1:0] rd_addr_q[$];
  logic [DW-1:0] out_d_q[$];
  logic          out_l_q[$];

  task automatic run_cmd(input logic [AW-1:0] base, input logic [AW:0] n, input int mode,
                         input int budget, input int restart_cyc);
    logic          pend_v, prev_stall, prev_l;
    logic [DW-1:0] pend_d, prev_d;
    nreads = 0; nout = 0; nlast = 0; ndone = 0; done_cyc = -1;
    first_rd_cyc = -1; first_out_cyc = -1; last_out_cyc = -1;
    occ_viol = 0; stall_viol = 0; occ = 0;
    busy_c1 = 1'b0; busy_after_done = 1'b1;
    rd_addr_q.delete(); out_d_q.delete(); out_l_q.delete();
    pend_v = 1'b0; pend_d = '0; prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      rf_rd_data = pend_v ? pend_d : 32'hDEADBEEF;
      start      = (cyc == 0) || (cyc == restart_cyc);
      base_addr  = (cyc == 0) ? base : 4'd9;
      num_words  = (cyc == 0) ? n : 5'd3;
      out_ready  = ready_for(mode, cyc);
      #1;
      if (cyc == 1) busy_c1 = busy;
      if (occ > 2) occ_viol++;
      if (prev_stall && (!out_valid || out_data !== prev_d || out_last !== prev_l)) stall_viol++;
      if (rf_rd_req) begin
        rd_addr_q.push_back(rf_rd_addr);
        if (nreads == 0) first_rd_cyc = cyc;
        nreads++;
        occ++;
      end
      if (out_valid && out_ready) begin
        out_d_q.push_back(out_data);
        out_l_q.push_back(out_last);
        if (nout == 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
        if (out_last) nlast++;
        nout++;
        occ--;
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
      prev_l = out_last;
      pend_v = rf_rd_req;
      pend_d = memv(rf_rd_addr);
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        busy_after_done = busy;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_stream(input string t, input logic [AW-1:0] base, input int n);
    logic [AW-1:0] a;
    check({t, "_nreads"}, nreads, n);
    check({t, "_nout"}, nout, n);
    check({t, "_nlast"}, nlast, (n > 0) ? 1 : 0);
    check({t, "_ndone"}, ndone, 1);
    check({t, "_busy_after_done"}, {31'd0, busy_after_done}, 32'd0);
    check({t, "_occ_viol"}, occ_viol, 0);
    check({t, "_stall_viol"}, stall_viol, 0);
    for (int k = 0; k < n; k++) begin
      a = base + k[AW-1:0];
      if (k < nreads) check($sformatf("%s_addr%0d", t, k), {28'd0, rd_addr_q[k]}, {28'd0, a});
      if (k < nout) begin
        check($sformatf("%s_data%0d", t, k), out_d_q[k], memv(a));
        check($sformatf("%s_last%0d", t, k), {31'd0, out_l_q[k]}, {31'd0, (k == n - 1)});
      end
    end
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; base_addr = '0; num_words = '0;
    rf_rd_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_req", {31'd0, rf_rd_req}, 0);
    check("rst_addr", {28'd0, rf_rd_addr}, 0);
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_data", out_data, 0);
    check("rst_last", {31'd0, out_last}, 0);
    resetn = 1'b1;

    // Basic 4-word read, no backpressure: exact cycle timing
    run_cmd(4'd3, 5'd4, 0, 20, -1);
    check_stream("t1", 4'd3, 4);
    check("t1_busy_c1", {31'd0, busy_c1}, 1);
    check("t1_first_rd", first_rd_cyc, 1);
    check("t1_first_out", first_out_cyc, 3);
    check("t1_last_out", last_out_cyc, 6);
    check("t1_done_cyc", done_cyc, 7);

    // Toggling ready
    run_cmd(4'd3, 5'd4, 1, 40, -1);
    check_stream("t2", 4'd3, 4);

    // Address wrap
    run_cmd(4'd14, 5'd4, 0, 20, -1);
    check_stream("t3", 4'd14, 4);
    check("t3_done_cyc", done_cyc, 7);

    // Full range
    run_cmd(4'd0, 5'd16, 0, 40, -1);
    check_stream("t4", 4'd0, 16);
    check("t4_done_cyc", done_cyc, 19);

    // Zero words
    run_cmd(4'd5, 5'd0, 0, 10, -1);
    check_stream("t5", 4'd5, 0);
    check("t5_busy_c1", {31'd0, busy_c1}, 1);
    check("t5_done_cyc", done_cyc, 2);

    // Start while busy is ignored
    run_cmd(4'd5, 5'd4, 0, 20, 2);
    check_stream("t6", 4'd5, 4);
    check("t6_done_cyc", done_cyc, 7);

    // Reset mid-command with consumer stalled
    run_cmd(4'd0, 5'd6, 2, 9, -1);
    check("t7_nout_pre", nout, 2);
    check("t7_nodone_pre", ndone, 0);
    check("t7_valid_pre", {31'd0, out_valid}, 1);
    @(negedge clk); #2;
    resetn = 1'b0;
    #1;
    check("t7_busy", {31'd0, busy}, 0);
    check("t7_req", {31'd0, rf_rd_req}, 0);
    check("t7_addr", {28'd0, rf_rd_addr}, 0);
    check("t7_valid", {31'd0, out_valid}, 0);
    check("t7_data", out_data, 0);
    check("t7_last", {31'd0, out_last}, 0);
    check("t7_done", {31'd0, done}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("t7_done_hold", {31'd0, done}, 0);
    resetn = 1'b1;
    run_cmd(4'd0, 5'd2, 0, 20, -1);
    check_stream("t7b", 4'd0, 2);
    check("t7b_done_cyc", done_cyc, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
